// File: rtl/hs_join_fork_ctrl.sv
// Clocked 4-phase handshake stage controller: N_IN-way join, latch enable with a
// programmable matched delay, N_OUT-way return-to-zero fork, error flag and token counter.
module hs_join_fork_ctrl #(
    parameter int N_IN    = 3,
    parameter int N_OUT   = 4,
    parameter int DELAY_W = 8,
    parameter int CNT_W   = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [N_IN-1:0]    req_in_i,
    output logic [N_IN-1:0]    ack_in_o,
    output logic [N_OUT-1:0]   req_out_o,
    input  logic [N_OUT-1:0]   ack_out_i,
    input  logic               start_i,
    input  logic [DELAY_W-1:0] delay_i,
    output logic               en_o,
    output logic               busy_o,
    output logic               err_o,
    output logic [CNT_W-1:0]   tokens_o
);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_LATCH     = 2'd1;
    localparam logic [1:0] ST_DELAY     = 2'd2;
    localparam logic [1:0] ST_HANDSHAKE = 2'd3;

    logic [1:0]         state_reg, state_next;
    logic [DELAY_W-1:0] cnt_reg, cnt_next;
    logic               internal_reg, internal_next;
    logic               ack_in_reg, ack_in_next;
    logic [N_OUT-1:0]   req_out_reg, req_out_next;
    logic [N_OUT-1:0]   hi_reg, hi_next;
    logic [N_OUT-1:0]   done_reg, done_next;
    logic               en_reg, en_next;
    logic               busy_reg, busy_next;
    logic               err_reg, err_next;
    logic [CNT_W-1:0]   tokens_reg, tokens_next;
    logic [N_IN-1:0]    req_prev_reg;
    logic [N_OUT-1:0]   ack_prev_reg;

    logic [N_OUT-1:0]   ack_spurious;
    logic               req_withdrawn;
    logic               start_busy;
    logic               hs_exit;

    // An ack may only rise on a branch that is requesting or already mid-RTZ.
    generate
        for (genvar gi = 0; gi < N_OUT; gi++) begin : g_branch_err
            assign ack_spurious[gi] = ack_out_i[gi] & ~ack_prev_reg[gi]
                                    & ~req_out_reg[gi] & ~hi_reg[gi];
        end
    endgenerate

    assign req_withdrawn = (|(req_prev_reg & ~req_in_i)) && (state_reg == ST_IDLE) && !ack_in_reg;
    assign start_busy    = start_i && busy_reg;
    assign hs_exit       = (state_reg == ST_HANDSHAKE) && (&done_reg) && (!ack_in_reg || internal_reg);

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        internal_next = internal_reg;
        ack_in_next   = ack_in_reg;
        req_out_next  = req_out_reg;
        hi_next       = hi_reg;
        done_next     = done_reg;
        en_next       = 1'b0;
        tokens_next   = tokens_reg;

        case (state_reg)
            ST_IDLE: begin
                if (&req_in_i) begin
                    state_next    = ST_LATCH;
                    en_next       = 1'b1;
                    cnt_next      = delay_i;
                    internal_next = 1'b0;
                end else if (start_i) begin
                    // Internal token skips the latch cycle, so one count is spent here.
                    internal_next = 1'b1;
                    if (delay_i == '0) begin
                        state_next   = ST_HANDSHAKE;
                        req_out_next = '1;
                    end else begin
                        state_next = ST_DELAY;
                        cnt_next   = delay_i - 1'b1;
                    end
                end
            end
            ST_LATCH: begin
                ack_in_next = 1'b1;
                if (cnt_reg == '0) begin
                    state_next   = ST_HANDSHAKE;
                    req_out_next = '1;
                end else begin
                    state_next = ST_DELAY;
                    cnt_next   = cnt_reg - 1'b1;
                end
            end
            ST_DELAY: begin
                if (cnt_reg == '0) begin
                    state_next   = ST_HANDSHAKE;
                    req_out_next = '1;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            default: begin
                req_out_next = req_out_reg & ~ack_out_i;
                hi_next      = hi_reg | (ack_out_i & req_out_reg);
                done_next    = done_reg | (hi_reg & ~ack_out_i);
                if (hs_exit) begin
                    state_next    = ST_IDLE;
                    hi_next       = '0;
                    done_next     = '0;
                    internal_next = 1'b0;
                    tokens_next   = tokens_reg + 1'b1;
                end
            end
        endcase

        // Input side returns to zero independently of the fork.
        if (ack_in_reg && (req_in_i == '0)) begin
            ack_in_next = 1'b0;
        end

        busy_next = (state_next != ST_IDLE);
        err_next  = err_reg | (|ack_spurious) | req_withdrawn | start_busy;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            internal_reg <= 1'b0;
            ack_in_reg   <= 1'b0;
            req_out_reg  <= '0;
            hi_reg       <= '0;
            done_reg     <= '0;
            en_reg       <= 1'b0;
            busy_reg     <= 1'b0;
            err_reg      <= 1'b0;
            tokens_reg   <= '0;
            req_prev_reg <= '0;
            ack_prev_reg <= '0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            internal_reg <= internal_next;
            ack_in_reg   <= ack_in_next;
            req_out_reg  <= req_out_next;
            hi_reg       <= hi_next;
            done_reg     <= done_next;
            en_reg       <= en_next;
            busy_reg     <= busy_next;
            err_reg      <= err_next;
            tokens_reg   <= tokens_next;
            req_prev_reg <= req_in_i;
            ack_prev_reg <= ack_out_i;
        end
    end

    assign ack_in_o  = {N_IN{ack_in_reg}};
    assign req_out_o = req_out_reg;
    assign en_o      = en_reg;
    assign busy_o    = busy_reg;
    assign err_o     = err_reg;
    assign tokens_o  = tokens_reg;

endmodule

// File: tb/tb_hs_join_fork_ctrl.sv
// Directed bench for hs_join_fork_ctrl: request-to-fork latency and token counts are
// queued when a token is launched and checked when the DUT produces them.
module tb_hs_join_fork_ctrl;

    localparam int N_IN  = 3;
    localparam int N_OUT = 4;
    localparam int DW    = 8;
    localparam int CW    = 4;

    logic            clk = 1'b0;
    logic            rst_ni = 1'b1;
    logic [N_IN-1:0] req_in = '0;
    logic [N_IN-1:0] ack_in;
    logic [N_OUT-1:0] req_out;
    logic [N_OUT-1:0] ack_out = '0;
    logic            start = 1'b0;
    logic [DW-1:0]   delay = '0;
    logic            en, busy, err;
    logic [CW-1:0]   tokens;

    always #5 clk = ~clk;

    hs_join_fork_ctrl #(
        .N_IN(N_IN), .N_OUT(N_OUT), .DELAY_W(DW), .CNT_W(CW)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .req_in_i(req_in), .ack_in_o(ack_in),
        .req_out_o(req_out), .ack_out_i(ack_out),
        .start_i(start), .delay_i(delay),
        .en_o(en), .busy_o(busy), .err_o(err), .tokens_o(tokens)
    );

    int            n_cmp = 0;
    int            n_bad = 0;
    int            lat_q[$];
    logic [CW-1:0] tok_q[$];
    logic [CW-1:0] model_tokens = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_ni  = 1'b0;
        req_in  = '0;
        ack_out = '0;
        start   = 1'b0;
        delay   = '0;
        step();
        step();
        rst_ni = 1'b1;
        step();
        model_tokens = '0;
        lat_q.delete();
        tok_q.delete();
    endtask

    // Launch a token by join (use_start=0) or start pulse; returns once req_out is all-high.
    task automatic launch(input bit use_start, input int d, input string tag);
        int n;
        int exp_lat;
        model_tokens = model_tokens + 1'b1;
        lat_q.push_back(use_start ? d : d + 1);
        tok_q.push_back(model_tokens);
        delay = DW'(d);
        if (use_start) start = 1'b1;
        else req_in = '1;
        step();
        start = 1'b0;
        delay = 8'hAA;
        chk({tag, "_en"}, en, use_start ? 0 : 1);
        chk({tag, "_busy"}, busy, 1);
        n = 0;
        while (req_out !== '1 && n < 400) begin
            step();
            n++;
            if (!use_start && n == 1) chk({tag, "_ackin"}, ack_in, 3'b111);
        end
        if (use_start) chk({tag, "_ackin"}, ack_in, 0);
        exp_lat = lat_q.pop_front();
        chk({tag, "_lat"}, n, exp_lat);
        $display("token %s launched: req_out after %0d cycles", tag, n);
    endtask

    task automatic ack_branch(input int k, input string tag);
        ack_out[k] = 1'b1;
        step();
        chk($sformatf("%s_clr%0d", tag, k), req_out[k], 0);
        ack_out[k] = 1'b0;
        step();
    endtask

    task automatic finish_token(input string tag);
        int n;
        logic [CW-1:0] exp_tok;
        req_in = '0;
        n = 0;
        while (busy && n < 50) begin
            step();
            n++;
        end
        chk({tag, "_idle"}, busy, 0);
        chk({tag, "_ackin0"}, ack_in, 0);
        exp_tok = (tok_q.size() > 0) ? tok_q.pop_front() : 'x;
        chk({tag, "_tokens"}, tokens, exp_tok);
        $display("token %s completed: tokens_o=%0d", tag, tokens);
    endtask

    initial begin
        #1;
        rst_ni = 1'b0;
        #1;
        chk("rst_ackin", ack_in, 0);
        chk("rst_reqout", req_out, 0);
        chk("rst_en", en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_tokens", tokens, 0);
        do_reset();

        // Join, zero delay, acks in order.
        launch(1'b0, 0, "t1");
        for (int k = 0; k < N_OUT; k++) ack_branch(k, "t1");
        finish_token("t1");

        // Programmed delays.
        launch(1'b0, 5, "t2a");
        for (int k = 0; k < N_OUT; k++) ack_branch(k, "t2a");
        finish_token("t2a");
        launch(1'b0, 255, "t2b");
        for (int k = 0; k < N_OUT; k++) ack_branch(k, "t2b");
        finish_token("t2b");

        // Internal start token.
        launch(1'b1, 2, "t3");
        for (int k = 0; k < N_OUT; k++) ack_branch(k, "t3");
        finish_token("t3");

        // Reverse-order acks, branch 0 late.
        launch(1'b0, 0, "t4");
        for (int k = N_OUT - 1; k > 0; k--) ack_branch(k, "t4");
        repeat (20) step();
        chk("t4_wait_busy", busy, 1);
        chk("t4_wait_req", req_out, 4'b0001);
        ack_branch(0, "t4");
        finish_token("t4");
        chk("t4_err", err, 0);

        // Spurious ack while idle.
        ack_out[2] = 1'b1;
        step();
        chk("t5a_err", err, 1);
        ack_out = '0;
        repeat (3) step();
        chk("t5a_sticky", err, 1);
        $display("protocol: spurious ack err=%0d", err);

        // Request withdrawn before the join.
        do_reset();
        chk("t5b_err_clr", err, 0);
        req_in = 3'b011;
        step();
        chk("t5b_err_pre", err, 0);
        req_in = '0;
        step();
        chk("t5b_err", err, 1);
        $display("protocol: withdrawn request err=%0d", err);

        // Start pulse while busy is flagged and ignored.
        do_reset();
        launch(1'b1, 3, "t5c");
        start = 1'b1;
        step();
        start = 1'b0;
        chk("t5c_err", err, 1);
        chk("t5c_req", req_out, 4'hF);
        for (int k = 0; k < N_OUT; k++) ack_branch(k, "t5c");
        finish_token("t5c");

        // Asynchronous reset in the middle of the fork.
        do_reset();
        launch(1'b0, 0, "t6");
        ack_branch(1, "t6");
        #3;
        rst_ni = 1'b0;
        #1;
        chk("t6_rst_ackin", ack_in, 0);
        chk("t6_rst_reqout", req_out, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_en", en, 0);
        chk("t6_rst_tokens", tokens, 0);
        $display("async reset mid-handshake: busy=%0d req_out=%0h", busy, req_out);
        req_in = '0;
        ack_out = '0;
        model_tokens = '0;
        lat_q.delete();
        tok_q.delete();
        step();
        rst_ni = 1'b1;
        step();
        launch(1'b0, 0, "t6b");
        for (int k = 0; k < N_OUT; k++) ack_branch(k, "t6b");
        finish_token("t6b");

        // Counter wrap: 15 more tokens bring the 4-bit count back to zero.
        for (int i = 0; i < 15; i++) begin
            launch(1'b1, 0, $sformatf("w%0d", i));
            for (int k = 0; k < N_OUT; k++) ack_branch(k, "w");
            finish_token($sformatf("w%0d", i));
        end
        chk("wrap_zero", tokens, 0);
        chk("final_err", err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
